yc422_to_444: RTL and testbench
===============================

Name: yc422_to_444

Overview:
- Chroma upsampler feeding the y2x colour-space converter.
- Accepts a 4:2:2 stream of one pixel per beat and emits one 4:4:4 pixel per beat.
- The 4:4:4 output (in_y / in_xb / in_xr) goes straight to y2x.
- Chroma for odd pixels is either replicated or interpolated from neighbouring pairs; valid/ready handshakes on both sides; full rate of 1 pixel/clock in both modes.

Parameters:
- DW, 8: component width; must match the y2x in_y / in_xb / in_xr width.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  2*DW  {chroma, luma}; chroma is Cb on even beats, Cr on odd beats
- in_sof  in  1  start of frame; meaningful on even beats only
- in_eol  in  1  end of line; meaningful on odd beats only
- cfg_mode  in  1  0 = replicate, 1 = average
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream ready
- out_y  out  DW  luma
- out_xb  out  DW  Cb
- out_xr  out  DW  Cr
- out_sof  out  1  first pixel of frame
- out_eol  out  1  last pixel of line
- err_eol_even  out  1  sticky flag: in_eol seen on an even beat; cleared by rst only

Behaviour:
- Beat phase toggles on each accepted beat, starting even after reset; it is also forced to even after an accepted odd beat with in_eol.
- Pair k = even beat (Y2k, Cb_k) followed by odd beat (Y2k+1, Cr_k).
- Storage:
  - Register B assembles the incoming pair: b_half, b_full.
  - Register A holds the pair being emitted: a_full, a_phase (next pixel 0/1), a_eol, a_sof.
- load = b_full && (!a_full || (a_phase==1 && out_valid && out_ready)).
  - On load, A <= B and a_phase <= 0.
  - In the same edge, B may accept a new even beat.
- in_ready = !rst && (!b_full || load).
  - This is a deliberate combinational path out_ready -> in_ready; there is no in_valid -> out_* path.
- Pixel 0 of A: out = (Y2k, Cb_k, Cr_k); out_sof = a_sof; out_eol = 0.
- Pixel 1 of A:
  - mode 0: (Y2k+1, Cb_k, Cr_k).
  - mode 1: (Y2k+1, (Cb_k+Cb_{k+1}+1)>>1, (Cr_k+Cr_{k+1}+1)>>1), using B as pair k+1. The sum is DW+1 bits and the result truncates to DW bits; no overflow is possible.
  - If a_eol: values replicate as in mode 0, and out_eol = 1.
- out_valid:
  - Pixel 0: a_full.
  - Pixel 1, mode 0 or a_eol: a_full.
  - Pixel 1, mode 1 and !a_eol: a_full && b_full.
- Outputs hold stable while out_valid && !out_ready.
- Latency with out_ready high: the odd beat is accepted at edge t, load occurs at edge t+1, pixel 0 is valid in the cycle after t+1. Steady state is one pixel per clock in both modes.
- cfg_mode is latched into an internal mode register when an even beat with in_sof is accepted. The mode register resets to 0; mid-frame changes of cfg_mode are ignored.
- in_eol on an even beat: err_eol_even is set, and the beat is treated as a normal even beat (eol ignored).
- in_sof on an odd beat is ignored.
- Reset (including mid-frame): a_full, b_full and the phase clear, partial pairs are dropped, and the mode register returns to 0.
  - Reset values: out_valid 0, out_y/out_xb/out_xr 0 (A data cleared), out_sof 0, out_eol 0, err_eol_even 0, in_ready 0 while rst is high.
- Line end in mode 1: A's pixel 1 is not held waiting for the next line's pair.

Decomposition:
- Shared package (also used by y2x):
  - DW default
  - in_data field offsets (luma low, chroma high)
  - mode constants MODE_REPL=0 and MODE_AVG=1
- One sub-module: chroma_avg (two DW-bit inputs -> rounded DW-bit mean), instanced twice (Cb and Cr).
- The pair-register and handshake control stays in the top module.

Test Plan:
- Mode 0, out_ready=1, one line of 2 pairs (Y 10,20,30,40; Cb 100,120; Cr 200,220; eol on beat 3):
  - Outputs (10,100,200), (20,100,200), (30,120,220), (40,120,220) on consecutive cycles; eol only on the last pixel.
- Mode 1, same line:
  - Pixel 1 = (20,110,210); last pair replicates to (40,120,220) with eol.
  - Rounding check: Cb 3 and 4 give an average of 4.
- Mode 1 with Cb 255 and 255:
  - Average is 255 (no wrap).
- Backpressure: out_ready toggles 1,0,0,1 during a 4-pair line:
  - Outputs are held stable while stalled and in_ready drops once B is full.
  - No pixel is lost or duplicated, and the pixel count equals the beat count.
- Reset mid-pair: rst is asserted one cycle after the even beat, then the line is restarted:
  - All outputs are 0 during reset and the first output comes from the new pair.
- in_eol on an even beat:
  - err_eol_even goes to 1 and stays 1 until rst.
  - cfg_mode changed mid-frame has no effect until the next sof beat.

Source files
------------

// File: rtl/yc422_to_444_pkg.sv
// yc422_to_444_pkg: shared widths, in_data field layout and mode codes for the 4:2:2 -> 4:4:4 path and y2x
package yc422_to_444_pkg;
  localparam int DW = 8;
  localparam int LUMA_FIELD = 0;
  localparam int CHROMA_FIELD = 1;
  localparam logic MODE_REPL = 1'b0;
  localparam logic MODE_AVG = 1'b1;
  typedef enum logic {PH_EVEN, PH_ODD} phase_t;
endpackage

// File: rtl/yc422_to_444_if.sv
// yc422_to_444_if: 4:2:2 input stream, 4:4:4 output stream, config and status of the chroma upsampler
interface yc422_to_444_if #(parameter int DW = yc422_to_444_pkg::DW) ();
  logic in_valid;
  logic in_ready;
  logic [2*DW-1:0] in_data;
  logic in_sof;
  logic in_eol;
  logic cfg_mode;
  logic out_valid;
  logic out_ready;
  logic [DW-1:0] out_y;
  logic [DW-1:0] out_xb;
  logic [DW-1:0] out_xr;
  logic out_sof;
  logic out_eol;
  logic err_eol_even;
  modport master (
    output in_valid, in_data, in_sof, in_eol, cfg_mode, out_ready,
    input in_ready, out_valid, out_y, out_xb, out_xr, out_sof, out_eol, err_eol_even
  );
  modport slave (
    input in_valid, in_data, in_sof, in_eol, cfg_mode, out_ready,
    output in_ready, out_valid, out_y, out_xb, out_xr, out_sof, out_eol, err_eol_even
  );
endinterface

// File: rtl/yc422_to_444_chroma_avg.sv
// chroma_avg: rounded mean of two chroma samples, computed one bit wider so it never wraps
module chroma_avg #(
  parameter int DW = yc422_to_444_pkg::DW
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] m
);
  logic [DW:0] s;
  assign s = {1'b0, a} + {1'b0, b} + (DW+1)'(1);
  assign m = s[DW:1];
endmodule

// File: rtl/yc422_to_444.sv
// yc422_to_444: pairs 4:2:2 beats into B, emits two 4:4:4 pixels per pair from A with replicated or averaged odd chroma
module yc422_to_444 #(
  parameter int DW = yc422_to_444_pkg::DW
) (
  input logic clk,
  input logic rst,
  yc422_to_444_if.slave bus
);
  import yc422_to_444_pkg::*;
  phase_t in_phase;
  logic [DW-1:0] in_y, in_c;
  logic [DW-1:0] b_y0, b_y1, b_cb, b_cr, a_y0, a_y1, a_cb, a_cr, avg_cb, avg_cr;
  logic b_half, b_full, b_sof, b_eol;
  logic a_full, a_phase, a_sof, a_eol;
  logic mode, err, load, fire, acc, avg, ov;
  assign in_y = bus.in_data[LUMA_FIELD*DW +: DW];
  assign in_c = bus.in_data[CHROMA_FIELD*DW +: DW];
  assign in_phase = b_half ? PH_ODD : PH_EVEN;
  assign avg = a_phase && mode == MODE_AVG && !a_eol;
  assign ov = a_full && (!avg || b_full);
  assign fire = ov && bus.out_ready;
  assign load = b_full && (!a_full || (a_phase && fire));
  assign bus.in_ready = !rst && (!b_full || load);
  assign acc = bus.in_valid && bus.in_ready;
  assign bus.out_valid = ov;
  assign bus.out_y = a_phase ? a_y1 : a_y0;
  assign bus.out_xb = avg ? avg_cb : a_cb;
  assign bus.out_xr = avg ? avg_cr : a_cr;
  assign bus.out_sof = a_sof && !a_phase;
  assign bus.out_eol = a_eol && a_phase;
  assign bus.err_eol_even = err;
  chroma_avg #(.DW(DW)) u_avg_cb (.a(a_cb), .b(b_cb), .m(avg_cb));
  chroma_avg #(.DW(DW)) u_avg_cr (.a(a_cr), .b(b_cr), .m(avg_cr));
  always_ff @(posedge clk) begin
    if (rst) begin
      {b_y0, b_y1, b_cb, b_cr, a_y0, a_y1, a_cb, a_cr} <= '0;
      {b_half, b_full, b_sof, b_eol, a_full, a_phase, a_sof, a_eol, mode, err} <= '0;
    end else begin
      if (acc && in_phase == PH_EVEN) begin
        b_y0 <= in_y;
        b_cb <= in_c;
        b_sof <= bus.in_sof;
        b_half <= 1'b1;
        if (bus.in_sof) mode <= bus.cfg_mode;
        if (bus.in_eol) err <= 1'b1;
      end
      if (acc && in_phase == PH_ODD) begin
        b_y1 <= in_y;
        b_cr <= in_c;
        b_eol <= bus.in_eol;
        b_half <= 1'b0;
      end
      b_full <= (acc && in_phase == PH_ODD) || (b_full && !load);
      if (load) begin
        {a_y0, a_y1, a_cb, a_cr} <= {b_y0, b_y1, b_cb, b_cr};
        a_sof <= b_sof;
        a_eol <= b_eol;
        a_full <= 1'b1;
        a_phase <= 1'b0;
      end else if (fire) begin
        a_full <= !a_phase;
        a_phase <= !a_phase;
      end
    end
  end
endmodule

// File: tb/tb_yc422_to_444.sv
// tb_yc422_to_444: directed 4:2:2 lines with a queue scoreboard checked by an output monitor
module tb_yc422_to_444;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int passes = 0;
  int beats = 0;
  int out_cnt = 0;
  bit bp_on = 0;
  bit saw_low = 0;
  bit stalled = 0;
  logic [26:0] q[$];
  logic [26:0] px, held, ex;
  yc422_to_444_if #(.DW(8)) bus ();
  yc422_to_444 #(.DW(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [26:0] pk(input int y, input int xb, input int xr, input bit s, input bit e);
    return {1'b1, 8'(y), 8'(xb), 8'(xr), s, e};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passes++;
  endtask
  task automatic send(input int y, input int c, input bit sof, input bit eol);
    int n = 0;
    bit rdy = 0;
    bus.in_data = {8'(c), 8'(y)};
    bus.in_sof = sof;
    bus.in_eol = eol;
    bus.in_valid = 1;
    do begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      checks++;
      $display("FAIL send_timeout: in_ready stayed 0 for beat y=%0d", y);
    end else beats++;
    bus.in_valid = 0;
  endtask
  task automatic drain(input string name);
    for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk(name, q.size(), 0);
  endtask
  task automatic reset_checks(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_y"}, bus.out_y, 0);
    chk({tag, "_out_xb"}, bus.out_xb, 0);
    chk({tag, "_out_xr"}, bus.out_xr, 0);
    chk({tag, "_sof_eol"}, {bus.out_sof, bus.out_eol}, 0);
    chk({tag, "_err"}, bus.err_eol_even, 0);
  endtask
  always @(negedge clk) begin
    if (rst) stalled = 0;
    else begin
      px = {bus.out_valid, bus.out_y, bus.out_xb, bus.out_xr, bus.out_sof, bus.out_eol};
      if (stalled) chk("hold_stable", px, held);
      if (bp_on && !bus.in_ready) saw_low = 1;
      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        if (q.size() == 0) begin
          checks++;
          $display("FAIL pixel_unexpected: got %h with empty scoreboard", px);
        end else begin
          ex = q.pop_front();
          chk("pixel", px, ex);
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      held = px;
    end
  end
  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int oc0;
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.in_sof = 0;
    bus.in_eol = 0;
    bus.cfg_mode = 0;
    bus.out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks("rst0");
    @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    #1;
    q.push_back(pk(10, 100, 200, 1, 0));
    q.push_back(pk(20, 100, 200, 0, 0));
    q.push_back(pk(30, 120, 220, 0, 0));
    q.push_back(pk(40, 120, 220, 0, 1));
    send(10, 100, 1, 0); send(20, 200, 0, 0); send(30, 120, 0, 0); send(40, 220, 0, 1);
    drain("drain_repl");
    bus.cfg_mode = 1;
    q.push_back(pk(10, 100, 200, 1, 0));
    q.push_back(pk(20, 110, 210, 0, 0));
    q.push_back(pk(30, 120, 220, 0, 0));
    q.push_back(pk(40, 120, 220, 0, 1));
    send(10, 100, 1, 0); send(20, 200, 0, 0); send(30, 120, 0, 0); send(40, 220, 0, 1);
    drain("drain_avg");
    q.push_back(pk(1, 3, 10, 1, 0));
    q.push_back(pk(2, 4, 11, 0, 0));
    q.push_back(pk(3, 4, 11, 0, 0));
    q.push_back(pk(4, 4, 11, 0, 1));
    send(1, 3, 1, 0); send(2, 10, 0, 0); send(3, 4, 0, 0); send(4, 11, 0, 1);
    drain("drain_round");
    q.push_back(pk(5, 255, 0, 1, 0));
    q.push_back(pk(6, 255, 1, 0, 0));
    q.push_back(pk(7, 255, 1, 0, 0));
    q.push_back(pk(8, 255, 1, 0, 1));
    send(5, 255, 1, 0); send(6, 0, 0, 0); send(7, 255, 0, 0); send(8, 1, 0, 1);
    drain("drain_sat");
    bus.cfg_mode = 0;
    for (int k = 0; k < 4; k++) begin
      q.push_back(pk(50 + 2*k, 60 + k, 70 + k, k == 0, 0));
      q.push_back(pk(51 + 2*k, 60 + k, 70 + k, 0, k == 3));
    end
    oc0 = out_cnt;
    beats = 0;
    bp_on = 1;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          send(50 + 2*k, 60 + k, k == 0, 0);
          send(51 + 2*k, 70 + k, 0, k == 3);
        end
        for (int i = 0; i < 40; i++) @(posedge clk);
        bp_on = 0;
      end
      begin
        int k = 0;
        while (bp_on) begin
          @(posedge clk);
          #1;
          bus.out_ready = (k % 4 == 0) || (k % 4 == 3);
          k++;
        end
        bus.out_ready = 1;
      end
    join
    drain("drain_bp");
    chk("bp_in_ready_drop", saw_low, 1);
    chk("bp_pixel_count", out_cnt - oc0, beats);
    send(90, 91, 1, 0);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    reset_checks("rst_mid");
    @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    #1;
    q.push_back(pk(11, 12, 14, 1, 0));
    q.push_back(pk(13, 12, 14, 0, 1));
    send(11, 12, 1, 0); send(13, 14, 0, 1);
    drain("drain_restart");
    q.push_back(pk(20, 30, 40, 1, 0));
    q.push_back(pk(21, 30, 40, 0, 0));
    q.push_back(pk(22, 50, 60, 0, 0));
    q.push_back(pk(23, 50, 60, 0, 1));
    send(20, 30, 1, 1);
    bus.cfg_mode = 1;
    send(21, 40, 0, 0); send(22, 50, 0, 0); send(23, 60, 0, 1);
    drain("drain_eol_even");
    chk("err_set", bus.err_eol_even, 1);
    q.push_back(pk(1, 10, 20, 1, 0));
    q.push_back(pk(2, 20, 30, 0, 0));
    q.push_back(pk(3, 30, 40, 0, 0));
    q.push_back(pk(4, 30, 40, 0, 1));
    send(1, 10, 1, 0); send(2, 20, 0, 0); send(3, 30, 0, 0); send(4, 40, 0, 1);
    drain("drain_mode_sof");
    chk("err_sticky", bus.err_eol_even, 1);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("err_cleared", bus.err_eol_even, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
